sipo_rx: RTL and testbench

Serial-in/parallel-out receiver that sits directly downstream of the 4-bit PISO shifter. It reassembles MSB-first serial frames into WIDTH-bit words and presents each word on a valid/ready output with a one-entry holding register. Frame-start and overrun are tracked with sticky error flags so the consumer can detect lost or broken words.

---
 rtl/sipo_pkg.sv | 20 ++
 rtl/sipo_hold.sv | 41 ++++
 rtl/sipo_rx.sv | 129 ++++++++++++
 tb/tb_sipo_rx.sv | 230 +++++++++++++++++++++++
 4 files changed

// File: rtl/sipo_pkg.sv
// sipo_pkg: shared types and constants for the sipo_rx serial receiver.
//   state_t    - receiver FSM states (IDLE, SHIFT)
//   MIN_WIDTH  - smallest legal word width
//   MAX_WIDTH  - largest legal word width
//   cnt_width  - bit counter width able to hold 0..width
package sipo_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  localparam int MIN_WIDTH = 2;
  localparam int MAX_WIDTH = 32;

  function automatic int cnt_width(input int width);
    return $clog2(width + 1);
  endfunction

endpackage

// File: rtl/sipo_hold.sv
// sipo_hold: one-entry valid/ready holding register for received words.
// Ports:
//   clk      - system clock, rising edge
//   rst      - asynchronous active-low reset
//   complete - one-cycle pulse: word carries a freshly assembled value
//   word     - assembled word, valid while complete=1
//   p_ready  - consumer ready
//   p_out    - held word, stable while p_valid=1
//   p_valid  - p_out holds an unconsumed word
//   overrun  - one-cycle pulse: a completed word was dropped
module sipo_hold #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             complete,
  input  logic [WIDTH-1:0] word,
  input  logic             p_ready,
  output logic [WIDTH-1:0] p_out,
  output logic             p_valid,
  output logic             overrun
);

  // A new word is accepted whenever the slot is empty or being drained on
  // the same edge, so a consume and a refill can coincide without loss.
  // A word arriving into a full, stalled slot is dropped and reported.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      p_out   <= '0;
      p_valid <= 1'b0;
    end else if (complete && (!p_valid || p_ready)) begin
      p_out   <= word;
      p_valid <= 1'b1;
    end else if (p_valid && p_ready) begin
      p_valid <= 1'b0;
    end
  end

  assign overrun = complete && p_valid && !p_ready;

endmodule

// File: rtl/sipo_rx.sv
// sipo_rx: serial-in/parallel-out receiver for MSB-first frames.
// Ports:
//   clk     - system clock, rising edge
//   rst     - asynchronous active-low reset
//   s_in    - serial data bit, MSB first
//   s_en    - bit strobe; s_in sampled only when s_en=1
//   frm     - frame start, qualified by s_en (s_in is the MSB)
//   p_ready - consumer ready
//   clr     - synchronous clear of ovr and ferr
//   p_out   - received word
//   p_valid - p_out holds an unconsumed word
//   busy    - a frame is partially received
//   ovr     - sticky: a completed word was dropped
//   ferr    - sticky: a frame was restarted before completion
module sipo_rx
  import sipo_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             s_in,
  input  logic             s_en,
  input  logic             frm,
  input  logic             p_ready,
  input  logic             clr,
  output logic [WIDTH-1:0] p_out,
  output logic             p_valid,
  output logic             busy,
  output logic             ovr,
  output logic             ferr
);

  localparam int CNT_W = cnt_width(WIDTH);

  if (WIDTH < MIN_WIDTH || WIDTH > MAX_WIDTH) begin : g_width_check
    $error("sipo_rx: WIDTH must lie in 2..32");
  end

  state_t           state, state_next;
  // Only the WIDTH-1 bits already received are stored; the final word is
  // formed combinationally with the incoming bit so it can be handed to the
  // holding register on the very edge that captures the last bit.
  logic [WIDTH-2:0] shreg, shreg_next;
  logic [CNT_W-1:0] cnt, cnt_next;
  logic [WIDTH-1:0] word;
  logic             complete;
  logic             ferr_set;
  logic             overrun;

  // State, shift register and bit counter.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
      shreg <= '0;
      cnt   <= '0;
    end else begin
      state <= state_next;
      shreg <= shreg_next;
      cnt   <= cnt_next;
    end
  end

  // Next-state logic. A strobe with frm in SHIFT restarts the frame with
  // the current bit as MSB; stale low bits are shifted out before the
  // restarted word can complete, so no explicit clear is needed.
  always_comb begin
    state_next = state;
    shreg_next = shreg;
    cnt_next   = cnt;
    complete   = 1'b0;
    ferr_set   = 1'b0;
    word       = {shreg, s_in};
    case (state)
      IDLE: begin
        if (s_en && frm) begin
          shreg_next = word[WIDTH-2:0];
          cnt_next   = CNT_W'(1);
          state_next = SHIFT;
        end
      end
      SHIFT: begin
        if (s_en) begin
          shreg_next = word[WIDTH-2:0];
          if (frm) begin
            ferr_set = 1'b1;
            cnt_next = CNT_W'(1);
          end else if (cnt == CNT_W'(WIDTH - 1)) begin
            complete   = 1'b1;
            cnt_next   = '0;
            state_next = IDLE;
          end else begin
            cnt_next = cnt + CNT_W'(1);
          end
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // Sticky error flags; a set event in the same cycle as clr wins.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ovr  <= 1'b0;
      ferr <= 1'b0;
    end else begin
      if (overrun)  ovr <= 1'b1;
      else if (clr) ovr <= 1'b0;
      if (ferr_set) ferr <= 1'b1;
      else if (clr) ferr <= 1'b0;
    end
  end

  assign busy = (state == SHIFT);

  sipo_hold #(
    .WIDTH(WIDTH)
  ) u_hold (
    .clk     (clk),
    .rst     (rst),
    .complete(complete),
    .word    (word),
    .p_ready (p_ready),
    .p_out   (p_out),
    .p_valid (p_valid),
    .overrun (overrun)
  );

endmodule

// File: tb/tb_sipo_rx.sv
// tb_sipo_rx: directed self-checking bench for sipo_rx with WIDTH=4.
module tb_sipo_rx;

  logic       clk;
  logic       rst;
  logic       s_in;
  logic       s_en;
  logic       frm;
  logic       p_ready;
  logic       clr;
  logic [3:0] p_out;
  logic       p_valid;
  logic       busy;
  logic       ovr;
  logic       ferr;

  int evaluated = 0;
  int failures  = 0;

  sipo_rx #(
    .WIDTH(4)
  ) dut (
    .clk    (clk),
    .rst    (rst),
    .s_in   (s_in),
    .s_en   (s_en),
    .frm    (frm),
    .p_ready(p_ready),
    .clr    (clr),
    .p_out  (p_out),
    .p_valid(p_valid),
    .busy   (busy),
    .ovr    (ovr),
    .ferr   (ferr)
  );

  // Free-running clock, period 10.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Safety net so the run always ends.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: observed timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  // Drive one cycle of strobe/frame inputs, then sample 1 time unit after
  // the edge. Strobe inputs return to idle afterwards.
  task automatic applyStimulus(input logic en, input logic bit_in, input logic start);
    s_en = en;
    s_in = bit_in;
    frm  = start;
    @(posedge clk);
    #1;
    s_en = 1'b0;
    s_in = 1'b0;
    frm  = 1'b0;
  endtask

  // Send a full 4-bit word MSB first on consecutive strobes.
  task automatic sendWord(input logic [3:0] w);
    for (int i = 3; i >= 0; i--) begin
      applyStimulus(1'b1, w[i], i == 3);
    end
  endtask

  task automatic checkOutput(input string tag, input logic [3:0] exp_out,
                             input logic exp_valid, input logic exp_busy,
                             input logic exp_ovr, input logic exp_ferr);
    evaluated++;
    assert (p_out === exp_out) else begin
      failures++;
      $error("[TB] FAIL %s p_out: observed %h expected %h", tag, p_out, exp_out);
    end
    evaluated++;
    assert (p_valid === exp_valid) else begin
      failures++;
      $error("[TB] FAIL %s p_valid: observed %b expected %b", tag, p_valid, exp_valid);
    end
    evaluated++;
    assert (busy === exp_busy) else begin
      failures++;
      $error("[TB] FAIL %s busy: observed %b expected %b", tag, busy, exp_busy);
    end
    evaluated++;
    assert (ovr === exp_ovr) else begin
      failures++;
      $error("[TB] FAIL %s ovr: observed %b expected %b", tag, ovr, exp_ovr);
    end
    evaluated++;
    assert (ferr === exp_ferr) else begin
      failures++;
      $error("[TB] FAIL %s ferr: observed %b expected %b", tag, ferr, exp_ferr);
    end
  endtask

  initial begin
    rst     = 1'b0;
    s_in    = 1'b0;
    s_en    = 1'b0;
    frm     = 1'b0;
    p_ready = 1'b0;
    clr     = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checkOutput("reset", 4'h0, 0, 0, 0, 0);
    rst = 1'b1;

    // 1. Basic receive of 1011
    $display("[TB] basic receive");
    applyStimulus(1'b1, 1'b1, 1'b1);
    checkOutput("basic_b1", 4'h0, 0, 1, 0, 0);
    applyStimulus(1'b1, 1'b0, 1'b0);
    checkOutput("basic_b2", 4'h0, 0, 1, 0, 0);
    applyStimulus(1'b1, 1'b1, 1'b0);
    checkOutput("basic_b3", 4'h0, 0, 1, 0, 0);
    applyStimulus(1'b1, 1'b1, 1'b0);
    checkOutput("basic_done", 4'hB, 1, 0, 0, 0);
    applyStimulus(1'b1, 1'b1, 1'b0);
    checkOutput("basic_no_frm_ignored", 4'hB, 1, 0, 0, 0);
    p_ready = 1'b1;
    applyStimulus(1'b0, 1'b0, 1'b0);
    p_ready = 1'b0;
    checkOutput("basic_consume", 4'hB, 0, 0, 0, 0);

    // 2. Strobe gaps, word 0110
    $display("[TB] strobe gaps");
    applyStimulus(1'b1, 1'b0, 1'b1);
    repeat (3) applyStimulus(1'b0, 1'b1, 1'b1);
    checkOutput("gap_hold1", 4'hB, 0, 1, 0, 0);
    applyStimulus(1'b1, 1'b1, 1'b0);
    repeat (3) applyStimulus(1'b0, 1'b0, 1'b0);
    applyStimulus(1'b1, 1'b1, 1'b0);
    repeat (3) applyStimulus(1'b0, 1'b0, 1'b0);
    checkOutput("gap_hold3", 4'hB, 0, 1, 0, 0);
    applyStimulus(1'b1, 1'b0, 1'b0);
    checkOutput("gap_done", 4'h6, 1, 0, 0, 0);
    p_ready = 1'b1;
    applyStimulus(1'b0, 1'b0, 1'b0);
    p_ready = 1'b0;
    checkOutput("gap_consume", 4'h6, 0, 0, 0, 0);

    // 3. Overrun: A unread, then 5 arrives
    $display("[TB] overrun");
    sendWord(4'hA);
    checkOutput("ovr_first", 4'hA, 1, 0, 0, 0);
    sendWord(4'h5);
    checkOutput("ovr_set", 4'hA, 1, 0, 1, 0);
    clr = 1'b1;
    applyStimulus(1'b0, 1'b0, 1'b0);
    clr = 1'b0;
    checkOutput("ovr_clr", 4'hA, 1, 0, 0, 0);
    p_ready = 1'b1;
    applyStimulus(1'b0, 1'b0, 1'b0);
    p_ready = 1'b0;
    checkOutput("ovr_consume", 4'hA, 0, 0, 0, 0);

    // 4. Frame error: 1,1 then restart with 1,0,0,1; clr collides with set
    $display("[TB] frame error");
    applyStimulus(1'b1, 1'b1, 1'b1);
    applyStimulus(1'b1, 1'b1, 1'b0);
    checkOutput("ferr_partial", 4'hA, 0, 1, 0, 0);
    clr = 1'b1;
    applyStimulus(1'b1, 1'b1, 1'b1);
    clr = 1'b0;
    checkOutput("ferr_set_wins", 4'hA, 0, 1, 0, 1);
    applyStimulus(1'b1, 1'b0, 1'b0);
    applyStimulus(1'b1, 1'b0, 1'b0);
    checkOutput("ferr_no_valid", 4'hA, 0, 1, 0, 1);
    applyStimulus(1'b1, 1'b1, 1'b0);
    checkOutput("ferr_word", 4'h9, 1, 0, 0, 1);
    clr     = 1'b1;
    p_ready = 1'b1;
    applyStimulus(1'b0, 1'b0, 1'b0);
    clr     = 1'b0;
    p_ready = 1'b0;
    checkOutput("ferr_clr", 4'h9, 0, 0, 0, 0);

    // 5. Back-to-back C then 3 with p_ready tied high
    $display("[TB] back-to-back");
    p_ready = 1'b1;
    sendWord(4'hC);
    checkOutput("b2b_first", 4'hC, 1, 0, 0, 0);
    applyStimulus(1'b1, 1'b0, 1'b1);
    checkOutput("b2b_drained", 4'hC, 0, 1, 0, 0);
    applyStimulus(1'b1, 1'b0, 1'b0);
    applyStimulus(1'b1, 1'b1, 1'b0);
    applyStimulus(1'b1, 1'b1, 1'b0);
    checkOutput("b2b_second", 4'h3, 1, 0, 0, 0);
    applyStimulus(1'b0, 1'b0, 1'b0);
    checkOutput("b2b_consume", 4'h3, 0, 0, 0, 0);

    // Same-edge consume and refill: D held, 7 completes while p_ready=1
    $display("[TB] lossless refill");
    p_ready = 1'b0;
    sendWord(4'hD);
    applyStimulus(1'b1, 1'b0, 1'b1);
    applyStimulus(1'b1, 1'b1, 1'b0);
    applyStimulus(1'b1, 1'b1, 1'b0);
    checkOutput("refill_held", 4'hD, 1, 1, 0, 0);
    p_ready = 1'b1;
    applyStimulus(1'b1, 1'b1, 1'b0);
    p_ready = 1'b0;
    checkOutput("refill_done", 4'h7, 1, 0, 0, 0);
    p_ready = 1'b1;
    applyStimulus(1'b0, 1'b0, 1'b0);
    p_ready = 1'b0;

    // 6. Reset mid-frame while F is held
    $display("[TB] reset mid-operation");
    sendWord(4'hF);
    applyStimulus(1'b1, 1'b0, 1'b1);
    applyStimulus(1'b1, 1'b1, 1'b0);
    checkOutput("rst_before", 4'hF, 1, 1, 0, 0);
    rst = 1'b0;
    #2;
    checkOutput("rst_async", 4'h0, 0, 0, 0, 0);
    @(posedge clk);
    #1;
    checkOutput("rst_held", 4'h0, 0, 0, 0, 0);
    rst = 1'b1;
    sendWord(4'h2);
    checkOutput("rst_after", 4'h2, 1, 0, 0, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", evaluated, failures);
    $finish;
  end

endmodule
